exception_ctrl: RTL and testbench

//  Exception/interrupt sequencer for the 5-stage MIPS pipeline; sits beside the hazard unit and sequences pipeline redirects.

---
 rtl/exc_pkg.sv | 29 ++
 rtl/exception_ctrl_irq_sync.sv | 31 +++
 rtl/exception_ctrl.sv | 178 +++++++++++++++++
 tb/tb_exception_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared constants for the exception sequencer: exception codes, CP0 register
// indices and the sequencer state encoding.
package exc_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH_IN  = 2'd1,
    ST_HANDLER   = 2'd2,
    ST_FLUSH_OUT = 2'd3
  } state_e;

  // Synchronous exceptions outrank interrupts, so INT is only the fallback code.
  function automatic logic [4:0] exc_code(input logic ov, input logic sys, input logic brk);
    if (ov)       return EXC_OV;
    else if (sys) return EXC_SYS;
    else if (brk) return EXC_BP;
    else          return EXC_INT;
  endfunction

endpackage

// File: rtl/exception_ctrl_irq_sync.sv
// Two-flop synchroniser for the asynchronous, level-sensitive interrupt lines.
module irq_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] irq_in,
  output logic [W-1:0] irq_out
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = irq_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign irq_out = sync_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer: prioritises EX-stage events, holds EPC/Cause/
// Status and drives the redirect plus flush/stall window around handler entry/exit.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0800,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          NUM_IRQ      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               overflow_ex,
  input  logic               syscall_ex,
  input  logic               break_ex,
  input  logic               eret_ex,
  input  logic [31:0]        pc_ex,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  output logic               pc_redirect,
  output logic [31:0]        redirect_addr,
  output logic               flush,
  output logic               stall_pc,
  output logic               in_handler
);

  localparam int            CW   = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FLUSH_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   epc_q, epc_d;
  logic [4:0]    code_q, code_d;
  logic          nested_q, nested_d;
  logic          exl_q, exl_d;
  logic          ie_q, ie_d;
  logic [7:0]    im_q, im_d;
  logic [1:0]    sw_ip_q, sw_ip_d;

  logic [NUM_IRQ-1:0] irq_s;
  logic [7:0]         hw_ip;
  logic               sync_exc;
  logic               irq_pend;
  logic               take_exc;
  logic               take_eret;

  irq_sync #(.W(NUM_IRQ)) u_irq_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq),
    .irq_out (irq_s)
  );

  always_comb begin
    hw_ip = '0;
    hw_ip[NUM_IRQ-1:0] = irq_s;
  end

  assign sync_exc  = overflow_ex | syscall_ex | break_ex;
  assign irq_pend  = (|(hw_ip & im_q)) & ie_q & ~exl_q;
  assign take_exc  = ((state_q == ST_RUN) && (sync_exc || irq_pend)) ||
                     ((state_q == ST_HANDLER) && sync_exc);
  assign take_eret = (state_q == ST_HANDLER) && !sync_exc && eret_ex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      epc_q    <= '0;
      code_q   <= '0;
      nested_q <= 1'b0;
      exl_q    <= 1'b0;
      ie_q     <= 1'b0;
      im_q     <= '0;
      sw_ip_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      code_q   <= code_d;
      nested_q <= nested_d;
      exl_q    <= exl_d;
      ie_q     <= ie_d;
      im_q     <= im_d;
      sw_ip_q  <= sw_ip_d;
    end
  end

  // Flush windows ignore EX inputs entirely; those instructions are being squashed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (take_exc) begin
          state_d = ST_FLUSH_IN;
          cnt_d   = '0;
        end
      end
      ST_HANDLER: begin
        if (take_exc) begin
          state_d = ST_FLUSH_IN;
          cnt_d   = '0;
        end else if (take_eret) begin
          state_d = ST_FLUSH_OUT;
          cnt_d   = '0;
        end
      end
      ST_FLUSH_IN, ST_FLUSH_OUT: begin
        if (cnt_q == LAST) begin
          state_d = (state_q == ST_FLUSH_IN) ? ST_HANDLER : ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Hardware updates win over an MTC0 to the same field in the same cycle.
  always_comb begin
    epc_d    = epc_q;
    code_d   = code_q;
    nested_d = nested_q;
    exl_d    = exl_q;
    ie_d     = ie_q;
    im_d     = im_q;
    sw_ip_d  = sw_ip_q;
    if (take_exc) begin
      epc_d  = pc_ex;
      code_d = exc_code(overflow_ex, syscall_ex, break_ex);
      exl_d  = 1'b1;
      ie_d   = 1'b0;
      if (state_q == ST_HANDLER) nested_d = 1'b1;
    end else if (take_eret) begin
      exl_d    = 1'b0;
      ie_d     = 1'b1;
      nested_d = 1'b0;
    end
    if (cp0_we) begin
      unique case (cp0_addr)
        CP0_STATUS: begin
          im_d = cp0_wdata[15:8];
          if (!take_exc && !take_eret) ie_d = cp0_wdata[0];
        end
        CP0_CAUSE: sw_ip_d = cp0_wdata[9:8];
        CP0_EPC:   if (!take_exc) epc_d = cp0_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    flush         = (state_q == ST_FLUSH_IN) || (state_q == ST_FLUSH_OUT);
    pc_redirect   = flush && (cnt_q == '0);
    stall_pc      = flush && (cnt_q != '0);
    redirect_addr = '0;
    if (pc_redirect)
      redirect_addr = (state_q == ST_FLUSH_IN) ? HANDLER_ADDR : epc_q;
    in_handler    = exl_q;
  end

  always_comb begin
    unique case (cp0_addr)
      CP0_STATUS: cp0_rdata = {16'h0, im_q, 6'h0, exl_q, ie_q};
      CP0_CAUSE:  cp0_rdata = {nested_q, 15'h0, hw_ip | {6'h0, sw_ip_q}, 1'b0, code_q, 2'b00};
      CP0_EPC:    cp0_rdata = epc_q;
      default:    cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed plus randomized bench for exception_ctrl, checked against an
// event-level model of the CP0 registers and flush window.
module tb_exception_ctrl;

  localparam logic [31:0] HANDLER = 32'h0000_0800;
  localparam int          FC      = 2;
  localparam int          NI      = 4;

  logic          clk;
  logic          rst_n;
  logic          overflow_ex, syscall_ex, break_ex, eret_ex;
  logic [31:0]   pc_ex;
  logic [NI-1:0] irq;
  logic          cp0_we;
  logic [4:0]    cp0_addr;
  logic [31:0]   cp0_wdata;
  logic [31:0]   cp0_rdata;
  logic          pc_redirect;
  logic [31:0]   redirect_addr;
  logic          flush, stall_pc, in_handler;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: busy counts remaining flush cycles; exl tells which way we are going.
  logic [31:0]   m_epc;
  logic [4:0]    m_code;
  logic          m_nested, m_exl, m_ie;
  logic [7:0]    m_im;
  logic [1:0]    m_sw;
  logic [NI-1:0] m_s1, m_s2;
  int            m_busy;

  exception_ctrl #(
    .HANDLER_ADDR (HANDLER),
    .FLUSH_CYCLES (FC),
    .NUM_IRQ      (NI)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .overflow_ex   (overflow_ex),
    .syscall_ex    (syscall_ex),
    .break_ex      (break_ex),
    .eret_ex       (eret_ex),
    .pc_ex         (pc_ex),
    .irq           (irq),
    .cp0_we        (cp0_we),
    .cp0_addr      (cp0_addr),
    .cp0_wdata     (cp0_wdata),
    .cp0_rdata     (cp0_rdata),
    .pc_redirect   (pc_redirect),
    .redirect_addr (redirect_addr),
    .flush         (flush),
    .stall_pc      (stall_pc),
    .in_handler    (in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [7:0] hw;
    logic       any_sync, irq_take;
    logic       hw_status, hw_epc;
    hw_status = 1'b0;
    hw_epc    = 1'b0;
    if (!rst_n) begin
      m_epc = '0; m_code = '0; m_nested = 0; m_exl = 0; m_ie = 0;
      m_im = '0; m_sw = '0; m_s1 = '0; m_s2 = '0; m_busy = 0;
      return;
    end
    hw       = {4'h0, m_s2};
    any_sync = overflow_ex | syscall_ex | break_ex;
    irq_take = !m_exl && m_ie && ((hw & m_im) != 8'h0);
    if (m_busy > 0) begin
      m_busy--;
    end else if (any_sync || irq_take) begin
      m_epc  = pc_ex;
      m_code = overflow_ex ? 5'd12 : syscall_ex ? 5'd8 : break_ex ? 5'd9 : 5'd0;
      if (m_exl) m_nested = 1'b1;
      m_exl = 1'b1; m_ie = 1'b0; m_busy = FC;
      hw_status = 1'b1; hw_epc = 1'b1;
    end else if (m_exl && eret_ex) begin
      m_exl = 1'b0; m_ie = 1'b1; m_nested = 1'b0; m_busy = FC;
      hw_status = 1'b1;
    end
    if (cp0_we) begin
      if (cp0_addr == 5'd12) begin
        m_im = cp0_wdata[15:8];
        if (!hw_status) m_ie = cp0_wdata[0];
      end else if (cp0_addr == 5'd13) begin
        m_sw = cp0_wdata[9:8];
      end else if (cp0_addr == 5'd14 && !hw_epc) begin
        m_epc = cp0_wdata;
      end
    end
    m_s2 = m_s1;
    m_s1 = irq;
  endtask

  task automatic check_output();
    logic        e_flush, e_redir;
    logic [31:0] e_addr, e_rd;
    e_flush = (m_busy > 0);
    e_redir = (m_busy == FC);
    e_addr  = e_redir ? (m_exl ? HANDLER : m_epc) : 32'h0;
    case (cp0_addr)
      5'd12:   e_rd = {16'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13:   e_rd = {m_nested, 15'h0, ({4'h0, m_s2} | {6'h0, m_sw}), 1'b0, m_code, 2'b00};
      5'd14:   e_rd = m_epc;
      default: e_rd = 32'h0;
    endcase
    check("flush",         {31'h0, flush},       {31'h0, e_flush});
    check("pc_redirect",   {31'h0, pc_redirect}, {31'h0, e_redir});
    check("stall_pc",      {31'h0, stall_pc},    {31'h0, e_flush && !e_redir});
    check("redirect_addr", redirect_addr,        e_addr);
    check("in_handler",    {31'h0, in_handler},  {31'h0, m_exl});
    check("cp0_rdata",     cp0_rdata,            e_rd);
  endtask

  task automatic apply_stimulus(input logic rstn, input logic ov, input logic sys,
                                input logic brk, input logic eret, input logic [31:0] pc,
                                input logic [NI-1:0] irq_v, input logic we,
                                input logic [4:0] addr, input logic [31:0] wdata);
    rst_n = rstn; overflow_ex = ov; syscall_ex = sys; break_ex = brk; eret_ex = eret;
    pc_ex = pc; irq = irq_v; cp0_we = we; cp0_addr = addr; cp0_wdata = wdata;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_output();
  endtask

  task automatic idle(input logic [4:0] addr, input logic [NI-1:0] irq_v);
    apply_stimulus(1, 0, 0, 0, 0, 32'h0, irq_v, 0, addr, 32'h0);
  endtask

  initial begin
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, '0, 0, 5'd14, 32'h0);
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, '0, 0, 5'd14, 32'h0);
    check("reset_epc", cp0_rdata, 32'h0);
    idle(5'd12, '0);

    // Overflow from RUN
    apply_stimulus(1, 1, 0, 0, 0, 32'h40, '0, 0, 5'd14, 32'h0);
    check("ov_redirect_addr", redirect_addr, HANDLER);
    check("ov_epc", cp0_rdata, 32'h40);
    idle(5'd13, '0);
    check("ov_flush_second", {31'h0, flush}, 32'h1);
    check("ov_code", {27'h0, cp0_rdata[6:2]}, 32'd12);
    idle(5'd12, '0);
    check("ov_flush_done", {31'h0, flush}, 32'h0);

    // Return through MTC0-adjusted EPC
    apply_stimulus(1, 0, 0, 0, 0, 32'h0, '0, 1, 5'd14, 32'h44);
    apply_stimulus(1, 0, 0, 0, 1, 32'h0, '0, 0, 5'd12, 32'h0);
    check("eret_addr", redirect_addr, 32'h44);
    check("eret_in_handler", {31'h0, in_handler}, 32'h0);
    check("eret_ie", {31'h0, cp0_rdata[0]}, 32'h1);
    idle(5'd12, '0);
    idle(5'd12, '0);

    // Interrupt taken through the synchroniser
    apply_stimulus(1, 0, 0, 0, 0, 32'h0, '0, 1, 5'd12, 32'h0000_0101);
    idle(5'd13, 4'h1);
    idle(5'd13, 4'h1);
    idle(5'd13, 4'h1);
    check("irq_redirect", {31'h0, pc_redirect}, 32'h1);
    check("irq_cause", cp0_rdata, 32'h0000_0100);
    idle(5'd13, 4'h1);
    idle(5'd13, 4'h1);
    idle(5'd13, '0);
    idle(5'd13, '0);
    apply_stimulus(1, 0, 0, 0, 1, 32'h0, '0, 0, 5'd12, 32'h0);
    idle(5'd12, '0);
    idle(5'd12, '0);

    // Masked interrupt never taken
    apply_stimulus(1, 0, 0, 0, 0, 32'h0, '0, 1, 5'd12, 32'h0000_0001);
    for (int i = 0; i < 6; i++) begin
      idle(5'd12, 4'h1);
      check("irq_masked", {31'h0, flush}, 32'h0);
    end
    idle(5'd12, '0);
    idle(5'd12, '0);

    // Simultaneous events, then break squashed during flush
    apply_stimulus(1, 1, 0, 1, 0, 32'h100, 4'h1, 0, 5'd13, 32'h0);
    check("prio_code", {27'h0, cp0_rdata[6:2]}, 32'd12);
    apply_stimulus(1, 0, 0, 1, 0, 32'h99, '0, 0, 5'd14, 32'h0);
    check("squash_epc", cp0_rdata, 32'h100);
    idle(5'd14, '0);

    // Nested syscall, then eret+break in the handler
    apply_stimulus(1, 0, 1, 0, 0, 32'h200, '0, 0, 5'd13, 32'h0);
    check("nested_cause", cp0_rdata, 32'h8000_0020);
    idle(5'd14, '0);
    check("nested_epc", cp0_rdata, 32'h200);
    idle(5'd13, '0);
    apply_stimulus(1, 0, 0, 1, 1, 32'h300, '0, 0, 5'd13, 32'h0);
    check("eret_brk_cause", cp0_rdata, 32'h8000_0024);
    check("eret_brk_target", redirect_addr, HANDLER);
    idle(5'd13, '0);
    idle(5'd13, '0);
    apply_stimulus(1, 0, 0, 0, 1, 32'h0, '0, 0, 5'd13, 32'h0);
    idle(5'd13, '0);
    idle(5'd13, '0);

    // Reset in the middle of the entry flush
    apply_stimulus(1, 0, 1, 0, 0, 32'h500, '0, 0, 5'd14, 32'h0);
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, '0, 0, 5'd14, 32'h0);
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_in_handler", {31'h0, in_handler}, 32'h0);
    check("rst_epc", cp0_rdata, 32'h0);
    idle(5'd12, '0);

    // Randomized traffic
    begin
      logic [NI-1:0] irq_r;
      logic [4:0]    addr_r;
      logic [31:0]   wd;
      logic [1:0]    pick;
      irq_r = '0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) irq_r = NI'($urandom);
        pick   = 2'($urandom_range(0, 3));
        addr_r = (pick == 2'd3) ? 5'($urandom) : 5'd12 + {3'b0, pick};
        wd     = $urandom;
        apply_stimulus($urandom_range(0, 499) != 0,
                       $urandom_range(0, 39) == 0,
                       $urandom_range(0, 39) == 0,
                       $urandom_range(0, 39) == 0,
                       $urandom_range(0, 5) == 0,
                       {$urandom, 2'b00} >> 2 << 2,
                       irq_r,
                       $urandom_range(0, 15) == 0,
                       addr_r, wd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
